// File: rtl/scr1_tcm_ctrl_pkg.sv
// Shared types and helpers for the TCM port-B controller:
// FSM state encoding and the byte merge used by read-modify-write.
package scr1_tcm_ctrl_pkg;

  localparam logic [3:0] SCR1_TCM_BE_FULL = 4'hF;

  typedef enum logic [1:0] {
    SCR1_TCM_FSM_IDLE    = 2'd0,
    SCR1_TCM_FSM_RD_RSP  = 2'd1,
    SCR1_TCM_FSM_WR_RSP  = 2'd2,
    SCR1_TCM_FSM_RMW_MRG = 2'd3
  } type_scr1_tcm_ctrl_fsm_e;

  // Byte i of the result comes from new_data when be[i] is set, else from old_data.
  function automatic logic [31:0] scr1_tcm_byte_merge(
    input logic [31:0] old_data,
    input logic [31:0] new_data,
    input logic [3:0]  be
  );
    logic [31:0] res;
    for (int i = 0; i < 4; i++) begin
      res[i*8 +: 8] = be[i] ? new_data[i*8 +: 8] : old_data[i*8 +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/scr1_tcm_rmw_ctrl.sv
// TCM port-B controller: maps single-requester data accesses onto port-B
// cycles, splitting partial writes into read + merged whole-word write.
module scr1_tcm_rmw_ctrl
  import scr1_tcm_ctrl_pkg::*;
#(
  parameter int SCR1_WIDTH = 32,
  parameter int SCR1_SIZE  = 'h10000,
  parameter bit RMW_EN     = 1'b1
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            req_i,
  output logic                            req_ack_o,
  input  logic                            req_we_i,
  input  logic [SCR1_WIDTH/8-1:0]         req_be_i,
  input  logic [$clog2(SCR1_SIZE)-1:2]    req_addr_i,
  input  logic [SCR1_WIDTH-1:0]           req_wdata_i,
  output logic                            resp_vld_o,
  output logic [SCR1_WIDTH-1:0]           resp_rdata_o,
  output logic                            mem_ren_o,
  output logic                            mem_wen_o,
  output logic [SCR1_WIDTH/8-1:0]         mem_web_o,
  output logic [$clog2(SCR1_SIZE)-1:2]    mem_addr_o,
  output logic [SCR1_WIDTH-1:0]           mem_wdata_o,
  input  logic [SCR1_WIDTH-1:0]           mem_rdata_i
);

  localparam int AW = $clog2(SCR1_SIZE);

  type_scr1_tcm_ctrl_fsm_e     state_q, state_d;
  logic [AW-1:2]               addr_q, addr_d;
  logic [SCR1_WIDTH/8-1:0]     be_q, be_d;
  logic [SCR1_WIDTH-1:0]       wdata_q, wdata_d;
  logic                        req_acc;
  logic                        req_none;
  logic                        req_direct;

  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    be_d         = be_q;
    wdata_d      = wdata_q;
    resp_vld_o   = 1'b0;
    resp_rdata_o = '0;
    mem_ren_o    = 1'b0;
    mem_wen_o    = 1'b0;
    mem_web_o    = '0;
    mem_addr_o   = '0;
    mem_wdata_o  = '0;

    req_ack_o  = (state_q != SCR1_TCM_FSM_RMW_MRG);
    req_acc    = req_i & req_ack_o;
    req_none   = (req_be_i == '0);
    // Without RMW support every non-empty write goes straight out with byte enables.
    req_direct = (req_be_i == SCR1_TCM_BE_FULL) | ~RMW_EN;

    case (state_q)
      SCR1_TCM_FSM_RMW_MRG: begin
        mem_wen_o   = 1'b1;
        mem_web_o   = SCR1_TCM_BE_FULL;
        mem_addr_o  = addr_q;
        mem_wdata_o = scr1_tcm_byte_merge(mem_rdata_i, wdata_q, be_q);
        state_d     = SCR1_TCM_FSM_WR_RSP;
      end
      default: begin
        if (state_q == SCR1_TCM_FSM_RD_RSP) begin
          resp_vld_o   = 1'b1;
          resp_rdata_o = mem_rdata_i;
        end
        if (state_q == SCR1_TCM_FSM_WR_RSP) begin
          resp_vld_o = 1'b1;
        end

        state_d = SCR1_TCM_FSM_IDLE;
        if (req_acc) begin
          if (!req_we_i) begin
            mem_ren_o  = 1'b1;
            mem_addr_o = req_addr_i;
            state_d    = SCR1_TCM_FSM_RD_RSP;
          end else if (req_none) begin
            state_d = SCR1_TCM_FSM_WR_RSP;
          end else if (req_direct) begin
            mem_wen_o   = 1'b1;
            mem_web_o   = req_be_i;
            mem_addr_o  = req_addr_i;
            mem_wdata_o = req_wdata_i;
            state_d     = SCR1_TCM_FSM_WR_RSP;
          end else begin
            mem_ren_o  = 1'b1;
            mem_addr_o = req_addr_i;
            addr_d     = req_addr_i;
            be_d       = req_be_i;
            wdata_d    = req_wdata_i;
            state_d    = SCR1_TCM_FSM_RMW_MRG;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= SCR1_TCM_FSM_IDLE;
      addr_q  <= '0;
      be_q    <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      be_q    <= be_d;
      wdata_q <= wdata_d;
    end
  end

endmodule

// File: tb/tb_scr1_tcm_rmw_ctrl.sv
// Bench for scr1_tcm_rmw_ctrl: vector table through an RMW-enabled instance with a
// response scoreboard, plus hand sequences for direct partial writes and reset mid-RMW.
module tb_scr1_tcm_rmw_ctrl;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  // RMW-enabled instance
  logic        req, we, ack, resp_vld, m_ren, m_wen;
  logic [3:0]  be, m_web;
  logic [13:0] addr, m_addr;
  logic [31:0] wdata, resp_rdata, m_wdata, m_rdata;
  // Direct-write instance
  logic        req2, we2, ack2, resp_vld2, m2_ren, m2_wen;
  logic [3:0]  be2, m2_web;
  logic [13:0] addr2, m2_addr;
  logic [31:0] wdata2, resp_rdata2, m2_wdata, m2_rdata;

  scr1_tcm_rmw_ctrl #(.SCR1_WIDTH(32), .SCR1_SIZE('h10000), .RMW_EN(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .req_i(req), .req_ack_o(ack), .req_we_i(we),
    .req_be_i(be), .req_addr_i(addr), .req_wdata_i(wdata), .resp_vld_o(resp_vld),
    .resp_rdata_o(resp_rdata), .mem_ren_o(m_ren), .mem_wen_o(m_wen), .mem_web_o(m_web),
    .mem_addr_o(m_addr), .mem_wdata_o(m_wdata), .mem_rdata_i(m_rdata)
  );

  scr1_tcm_rmw_ctrl #(.SCR1_WIDTH(32), .SCR1_SIZE('h10000), .RMW_EN(1'b0)) dut_direct (
    .clk(clk), .rst_n(rst_n), .req_i(req2), .req_ack_o(ack2), .req_we_i(we2),
    .req_be_i(be2), .req_addr_i(addr2), .req_wdata_i(wdata2), .resp_vld_o(resp_vld2),
    .resp_rdata_o(resp_rdata2), .mem_ren_o(m2_ren), .mem_wen_o(m2_wen), .mem_web_o(m2_web),
    .mem_addr_o(m2_addr), .mem_wdata_o(m2_wdata), .mem_rdata_i(m2_rdata)
  );

  // Byte-writable memories with registered read data, plus a backdoor preload port
  logic [31:0] mem1 [0:255];
  logic [31:0] mem2 [0:255];
  logic        bd_we = 1'b0;
  logic [7:0]  bd_addr = 8'h0;
  logic [31:0] bd_data = 32'h0;

  always @(posedge clk) begin
    if (bd_we) begin
      mem1[bd_addr] <= bd_data;
      mem2[bd_addr] <= bd_data;
    end
    if (m_ren) m_rdata <= mem1[m_addr[7:0]];
    if (m2_ren) m2_rdata <= mem2[m2_addr[7:0]];
    for (int b = 0; b < 4; b++) begin
      if (m_wen && m_web[b]) mem1[m_addr[7:0]][b*8 +: 8] <= m_wdata[b*8 +: 8];
      if (m2_wen && m2_web[b]) mem2[m2_addr[7:0]][b*8 +: 8] <= m2_wdata[b*8 +: 8];
    end
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_vec = 0;
  int n_bad = 0;

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%h, expected 0x%h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check1(input string name, input logic act, input logic exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %b, expected %b (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Scoreboard: expected response cycle and read data
  typedef struct {
    int          due;
    logic [31:0] data;
  } sb_t;
  sb_t sbq[$];
  sb_t sb;

  always @(negedge clk) begin
    if (sbq.size() > 0 && sbq[0].due < cyc) begin
      n_vec++;
      n_bad++;
      $display("FAIL resp_missing: no response by cycle %0d, expected at %0d", cyc, sbq[0].due);
      void'(sbq.pop_front());
    end
    if (resp_vld) begin
      if (sbq.size() == 0) begin
        n_vec++;
        n_bad++;
        $display("FAIL resp_unexpected: resp_vld_o=1 at cycle %0d, expected none", cyc);
      end else begin
        sb = sbq.pop_front();
        check32("resp_cycle", cyc, sb.due);
        check32("resp_rdata", resp_rdata, sb.data);
      end
    end else begin
      check32("rdata_idle", resp_rdata, 32'h0);
    end
  end

  typedef struct {
    logic        we;
    logic [3:0]  be;
    logic [13:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp;    // read data, or word content after the write
  } vec_t;
  vec_t vtab [14];

  task automatic apply(input vec_t v);
    logic partial;
    partial = v.we && (v.be != 4'hF) && (v.be != 4'h0);
    @(posedge clk); #1;
    req = 1'b1; we = v.we; be = v.be; addr = v.addr; wdata = v.wdata;
    @(negedge clk);
    check1("req_ack", ack, 1'b1);
    check1("mem_ren", m_ren, !v.we || partial);
    check1("mem_wen", m_wen, v.we && (v.be == 4'hF));
    if (!v.we || v.be != 4'h0) check32("mem_addr", 32'(m_addr), 32'(v.addr));
    if (v.we && v.be == 4'hF) begin
      check32("mem_web", 32'(m_web), 32'hF);
      check32("mem_wdata", m_wdata, v.wdata);
    end
    sbq.push_back('{cyc + (partial ? 2 : 1), v.we ? 32'h0 : v.exp});
    if (partial) begin
      @(posedge clk); #1;
      req = 1'b0;
      @(negedge clk);
      check1("rmw_ack_low", ack, 1'b0);
      check1("rmw_wen", m_wen, 1'b1);
      check1("rmw_ren", m_ren, 1'b0);
      check32("rmw_web", 32'(m_web), 32'hF);
      check32("rmw_addr", 32'(m_addr), 32'(v.addr));
      check32("rmw_wdata", m_wdata, v.exp);
    end
  endtask

  task automatic preload(input logic [7:0] a, input logic [31:0] d);
    @(posedge clk); #1;
    bd_we = 1'b1; bd_addr = a; bd_data = d;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    req = 1'b0; we = 1'b0; be = 4'h0; addr = '0; wdata = '0;
    req2 = 1'b0; we2 = 1'b0; be2 = 4'h0; addr2 = '0; wdata2 = '0;

    vtab[0]  = '{1'b0, 4'h0, 14'h10, 32'h00000000, 32'hDEADBEEF};
    vtab[1]  = '{1'b1, 4'hF, 14'h20, 32'h12345678, 32'h12345678};
    vtab[2]  = '{1'b0, 4'h0, 14'h20, 32'h00000000, 32'h12345678};
    vtab[3]  = '{1'b1, 4'h5, 14'h30, 32'hAABBCCDD, 32'h11BB33DD};
    vtab[4]  = '{1'b0, 4'h0, 14'h30, 32'h00000000, 32'h11BB33DD};
    vtab[5]  = '{1'b1, 4'h0, 14'h40, 32'hFFFFFFFF, 32'hCAFEF00D};
    vtab[6]  = '{1'b0, 4'h0, 14'h40, 32'h00000000, 32'hCAFEF00D};
    vtab[7]  = '{1'b1, 4'h8, 14'h40, 32'h99000000, 32'h99FEF00D};
    vtab[8]  = '{1'b1, 4'h1, 14'h40, 32'h00000077, 32'h99FEF077};
    vtab[9]  = '{1'b0, 4'h0, 14'h40, 32'h00000000, 32'h99FEF077};
    vtab[10] = '{1'b1, 4'hF, 14'h50, 32'hA5A5A5A5, 32'hA5A5A5A5};
    vtab[11] = '{1'b0, 4'h0, 14'h50, 32'h00000000, 32'hA5A5A5A5};
    vtab[12] = '{1'b1, 4'h6, 14'h50, 32'h00123400, 32'hA51234A5};
    vtab[13] = '{1'b0, 4'h0, 14'h50, 32'h00000000, 32'hA51234A5};

    #2 rst_n = 1'b0;
    #1;
    check1("rst_ack", ack, 1'b1);
    check1("rst_resp_vld", resp_vld, 1'b0);
    check32("rst_resp_rdata", resp_rdata, 32'h0);
    check1("rst_mem_ren", m_ren, 1'b0);
    check1("rst_mem_wen", m_wen, 1'b0);
    check32("rst_mem_web", 32'(m_web), 32'h0);
    check32("rst_mem_addr", 32'(m_addr), 32'h0);
    check32("rst_mem_wdata", m_wdata, 32'h0);

    preload(8'h10, 32'hDEADBEEF);
    preload(8'h30, 32'h11223344);
    preload(8'h40, 32'hCAFEF00D);
    preload(8'h60, 32'h55555555);
    @(posedge clk); #1 bd_we = 1'b0;
    @(negedge clk) rst_n = 1'b1;

    for (int i = 0; i < 14; i++) apply(vtab[i]);
    @(posedge clk); #1 req = 1'b0;
    repeat (3) @(posedge clk);
    check32("mem_be0_unchanged", mem1[8'h40], 32'h99FEF077);

    // Direct partial write on the instance without RMW
    @(posedge clk); #1;
    req2 = 1'b1; we2 = 1'b1; be2 = 4'h5; addr2 = 14'h30; wdata2 = 32'hAABBCCDD;
    @(negedge clk);
    check1("dir_ack", ack2, 1'b1);
    check1("dir_ren", m2_ren, 1'b0);
    check1("dir_wen", m2_wen, 1'b1);
    check32("dir_web", 32'(m2_web), 32'h5);
    check32("dir_wdata", m2_wdata, 32'hAABBCCDD);
    @(posedge clk); #1 req2 = 1'b0;
    @(negedge clk);
    check1("dir_resp_vld", resp_vld2, 1'b1);
    check32("dir_resp_rdata", resp_rdata2, 32'h0);
    check1("dir_no_wen", m2_wen, 1'b0);
    @(posedge clk); #1;
    check1("dir_resp_done", resp_vld2, 1'b0);
    check32("dir_mem", mem2[8'h30], 32'h11BB33DD);

    // Reset while in the merge cycle of a partial write
    @(posedge clk); #1;
    req = 1'b1; we = 1'b1; be = 4'h3; addr = 14'h60; wdata = 32'h0;
    @(posedge clk); #1;
    req = 1'b0;
    check1("mrg_wen_before_rst", m_wen, 1'b1);
    rst_n = 1'b0;
    #1;
    check1("mrg_rst_wen", m_wen, 1'b0);
    check1("mrg_rst_ren", m_ren, 1'b0);
    check1("mrg_rst_resp", resp_vld, 1'b0);
    check1("mrg_rst_ack", ack, 1'b1);
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check32("mrg_rst_mem", mem1[8'h60], 32'h55555555);
    check1("mrg_rst_idle_ack", ack, 1'b1);

    check32("sb_drained", sbq.size(), 32'h0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
